// File: rtl/push_pacer.sv
// push_pacer: FIFO that releases its head as a registered single-cycle strobe, at most one per GAP+1 cycles.
// Latency: accept at edge N, strobe after edge N+1. Backpressure: in_ready = not full (no bypass), low in reset.
// Optional PUSH_PACER_COUNT_EN adds a 16-bit push_count output.
module push_pacer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int GAP   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     push_valid,
  output logic [WIDTH-1:0]         push_data,
  output logic [$clog2(DEPTH):0]   level
`ifdef PUSH_PACER_COUNT_EN
  ,
  output logic [15:0]              push_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [3:0]    GAP_LD   = 4'(GAP);

  typedef enum logic [1:0] {IDLE, PUSH, HOLD} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [3:0]        gap_q, gap_d;
  logic              push_valid_q, push_valid_d;
  logic [WIDTH-1:0]  push_data_q, push_data_d;
  logic              accept;
  logic              pop;

  assign in_ready   = rst_n && (level_q != FULL_LVL);
  assign push_valid = push_valid_q;
  assign push_data  = push_data_q;
  assign level      = level_q;

  // PUSH is held exactly when the FIFO is non-empty and the gap counter is 0.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    gap_d        = gap_q;
    push_valid_d = 1'b0;
    push_data_d  = push_data_q;
    accept       = 1'b0;
    pop          = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      gap_d    = '0;
      state_d  = IDLE;
    end else begin
      accept = in_valid && in_ready;
      pop    = (state_q == PUSH);
      if (pop) begin
        push_valid_d = 1'b1;
        push_data_d  = mem_q[rd_ptr_q];
        rd_ptr_d     = rd_ptr_q + 1'b1;
        gap_d        = GAP_LD;
      end else if (gap_q != 4'd0) begin
        gap_d = gap_q - 1'b1;
      end
      if (accept) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      case ({accept, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (gap_d != 4'd0) begin
        state_d = HOLD;
      end else if (level_d != '0) begin
        state_d = PUSH;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      gap_q        <= '0;
      push_valid_q <= 1'b0;
      push_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      gap_q        <= gap_d;
      push_valid_q <= push_valid_d;
      push_data_q  <= push_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef PUSH_PACER_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else if (push_valid_q) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign push_count = count_q;
`endif

endmodule
